// File: rtl/alarm_clock.sv
// 24-hour alarm clock driven by a 2 Hz tick.
// Keeps hh:mm:ss plus an alarm hh:mm in binary counters. Time-set and
// alarm-set modes advance the selected field on each edge while runset is low.
// A latched alarm flag is raised one edge after the time reaches the alarm time.
module alarm_clock (
  input  logic       CLK_2Hz,
  input  logic       reset,
  input  logic       time_set,
  input  logic       alarm_set,
  input  logic       sethrs1min0,
  input  logic       run_clock,
  input  logic       activatealarm,
  input  logic       alarmreset,
  input  logic       runset,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hrs,
  output logic [7:0] min_alrm,
  output logic [7:0] hrs_alrm,
  output logic       alrm
);

  // Modulo-60 increment used for seconds and minutes fields.
  function automatic logic [5:0] inc_mod60(input logic [5:0] v);
    if (v == 6'd59) begin
      return 6'd0;
    end else begin
      return v + 6'd1;
    end
  endfunction

  // Modulo-24 increment used for hours fields.
  function automatic logic [4:0] inc_mod24(input logic [4:0] v);
    if (v == 5'd23) begin
      return 5'd0;
    end else begin
      return v + 5'd1;
    end
  endfunction

  logic [5:0] sec_r, sec_s;
  logic [5:0] min_r, min_s;
  logic [4:0] hrs_r, hrs_s;
  logic [5:0] min_alrm_r, min_alrm_s;
  logic [4:0] hrs_alrm_r, hrs_alrm_s;
  logic       phase_r, phase_s;
  logic       alrm_r, alrm_s;
  logic       match_s;

  // Next-state for time, alarm-setting and half-second phase (mode priority: time_set > alarm_set > run_clock).
  always_comb begin
    sec_s      = sec_r;
    min_s      = min_r;
    hrs_s      = hrs_r;
    min_alrm_s = min_alrm_r;
    hrs_alrm_s = hrs_alrm_r;
    phase_s    = phase_r;
    if (time_set) begin
      // Setting the time restarts the current minute cleanly.
      sec_s   = 6'd0;
      phase_s = 1'b0;
      if (!runset) begin
        if (sethrs1min0) begin
          hrs_s = inc_mod24(hrs_r);
        end else begin
          min_s = inc_mod60(min_r);
        end
      end else begin
        hrs_s = hrs_r;
      end
    end else begin
      if (alarm_set && !runset) begin
        if (sethrs1min0) begin
          hrs_alrm_s = inc_mod24(hrs_alrm_r);
        end else begin
          min_alrm_s = inc_mod60(min_alrm_r);
        end
      end else begin
        hrs_alrm_s = hrs_alrm_r;
      end
      // Timekeeping keeps running during alarm setting when enabled.
      if (run_clock) begin
        phase_s = ~phase_r;
        if (phase_r) begin
          sec_s = inc_mod60(sec_r);
          if (sec_r == 6'd59) begin
            min_s = inc_mod60(min_r);
            if (min_r == 6'd59) begin
              hrs_s = inc_mod24(hrs_r);
            end else begin
              hrs_s = hrs_r;
            end
          end else begin
            min_s = min_r;
          end
        end else begin
          sec_s = sec_r;
        end
      end else begin
        phase_s = phase_r;
      end
    end
  end

  // Alarm match on the current (pre-edge) time and the latched-flag next state.
  always_comb begin
    match_s = activatealarm && (hrs_r == hrs_alrm_r) && (min_r == min_alrm_r) && (sec_r == 6'd0);
    if (!alarmreset) begin
      alrm_s = 1'b0;
    end else if (match_s && !time_set) begin
      alrm_s = 1'b1;
    end else begin
      alrm_s = alrm_r;
    end
  end

  // State registers with asynchronous active-high clear.
  always_ff @(posedge CLK_2Hz or posedge reset) begin
    if (reset) begin
      sec_r      <= 6'd0;
      min_r      <= 6'd0;
      hrs_r      <= 5'd0;
      min_alrm_r <= 6'd0;
      hrs_alrm_r <= 5'd0;
      phase_r    <= 1'b0;
      alrm_r     <= 1'b0;
    end else begin
      sec_r      <= sec_s;
      min_r      <= min_s;
      hrs_r      <= hrs_s;
      min_alrm_r <= min_alrm_s;
      hrs_alrm_r <= hrs_alrm_s;
      phase_r    <= phase_s;
      alrm_r     <= alrm_s;
    end
  end

  assign sec      = {2'b00, sec_r};
  assign min      = {2'b00, min_r};
  assign hrs      = {3'b000, hrs_r};
  assign min_alrm = {2'b00, min_alrm_r};
  assign hrs_alrm = {3'b000, hrs_alrm_r};
  assign alrm     = alrm_r;

endmodule

// File: tb/tb_alarm_clock.sv
// Self-checking bench for alarm_clock: expected snapshots are queued when
// stimulus is applied and popped for comparison when the outputs are sampled.
module tb_alarm_clock;

  logic       clk;
  logic       reset;
  logic       time_set;
  logic       alarm_set;
  logic       sethrs1min0;
  logic       run_clock;
  logic       activatealarm;
  logic       alarmreset;
  logic       runset;
  logic [7:0] sec;
  logic [7:0] min;
  logic [7:0] hrs;
  logic [7:0] min_alrm;
  logic [7:0] hrs_alrm;
  logic       alrm;

  typedef struct {
    string       name;
    logic [40:0] exp;
  } sb_t;

  sb_t sb[$];
  sb_t e;
  int  n_checks = 0;
  int  n_fail   = 0;

  alarm_clock dut (
    .CLK_2Hz      (clk),
    .reset        (reset),
    .time_set     (time_set),
    .alarm_set    (alarm_set),
    .sethrs1min0  (sethrs1min0),
    .run_clock    (run_clock),
    .activatealarm(activatealarm),
    .alarmreset   (alarmreset),
    .runset       (runset),
    .sec          (sec),
    .min          (min),
    .hrs          (hrs),
    .min_alrm     (min_alrm),
    .hrs_alrm     (hrs_alrm),
    .alrm         (alrm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected snapshot {hrs, min, sec, hrs_alrm, min_alrm, alrm}.
  function automatic logic [40:0] mk(input int h, input int m, input int s,
                                     input int ha, input int ma, input bit a);
    logic [7:0] h8, m8, s8, ha8, ma8;
    h8 = h[7:0]; m8 = m[7:0]; s8 = s[7:0]; ha8 = ha[7:0]; ma8 = ma[7:0];
    return {h8, m8, s8, ha8, ma8, a};
  endfunction

  function automatic logic [40:0] obs();
    return {hrs, min, sec, hrs_alrm, min_alrm, alrm};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic idle_inputs();
    time_set      = 1'b0;
    alarm_set     = 1'b0;
    sethrs1min0   = 1'b0;
    run_clock     = 1'b0;
    activatealarm = 1'b0;
    alarmreset    = 1'b1;
    runset        = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    sb.push_back('{"reset_state", mk(0, 0, 0, 0, 0, 1'b0)});
    @(negedge clk);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.exp); end
    reset = 1'b0;
    // Idle inputs with run_clock=0 must hold everything.
    sb.push_back('{"idle_hold", mk(0, 0, 0, 0, 0, 1'b0)});
    step(4);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.exp); end
  endtask

  task automatic test_time_set();
    time_set = 1'b1; sethrs1min0 = 1'b0; runset = 1'b0;
    sb.push_back('{"tset_min29", mk(0, 29, 0, 0, 0, 1'b0)});
    step(29);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.exp); end
    sethrs1min0 = 1'b1;
    sb.push_back('{"tset_hrs5", mk(5, 29, 0, 0, 0, 1'b0)});
    step(5);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.exp); end
    runset = 1'b1;
    sb.push_back('{"tset_runset_high_holds", mk(5, 29, 0, 0, 0, 1'b0)});
    step(3);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.exp); end
    time_set = 1'b0;
  endtask

  task automatic test_alarm_set();
    alarm_set = 1'b1; sethrs1min0 = 1'b0; runset = 1'b0;
    step(30);
    sethrs1min0 = 1'b1;
    sb.push_back('{"aset_05_30", mk(5, 29, 0, 5, 30, 1'b0)});
    step(5);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.exp); end
    runset = 1'b1; alarm_set = 1'b0; sethrs1min0 = 1'b0;
  endtask

  task automatic test_run_alarm();
    run_clock = 1'b1; activatealarm = 1'b1;
    sb.push_back('{"run_half_min", mk(5, 29, 30, 5, 30, 1'b0)});
    step(60);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.exp); end
    sb.push_back('{"run_reach_alarm", mk(5, 30, 0, 5, 30, 1'b0)});
    step(60);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.exp); end
    sb.push_back('{"alarm_latch", mk(5, 30, 0, 5, 30, 1'b1)});
    step(1);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.exp); end
    sb.push_back('{"alarm_held", mk(5, 30, 6, 5, 30, 1'b1)});
    step(11);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.exp); end
    activatealarm = 1'b0;
    sb.push_back('{"deactivate_keeps_alrm", mk(5, 30, 7, 5, 30, 1'b1)});
    step(2);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.exp); end
  endtask

  task automatic test_alarm_clear();
    alarmreset = 1'b0;
    sb.push_back('{"alarmreset_clears", mk(5, 30, 7, 5, 30, 1'b0)});
    step(1);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.exp); end
    alarmreset = 1'b1;
    sb.push_back('{"alrm_stays_clear", mk(5, 30, 8, 5, 30, 1'b0)});
    step(2);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.exp); end
    idle_inputs();
    reset = 1'b1;
    sb.push_back('{"reset_after_alarm", mk(0, 0, 0, 0, 0, 1'b0)});
    step(1);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.exp); end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    // Time 00:00:00 equals alarm 00:00; clear must win over a simultaneous match.
    activatealarm = 1'b1; alarmreset = 1'b0;
    sb.push_back('{"clear_beats_match", mk(0, 0, 0, 0, 0, 1'b0)});
    step(1);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.exp); end
    alarmreset = 1'b1;
    sb.push_back('{"frozen_match_latches", mk(0, 0, 0, 0, 0, 1'b1)});
    step(1);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.exp); end
    alarmreset = 1'b0;
    step(1);
    alarmreset = 1'b1; time_set = 1'b1;
    sb.push_back('{"time_set_blocks_latch", mk(0, 0, 0, 0, 0, 1'b0)});
    step(2);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.exp); end
    // Alarm setting while the clock runs: both advance.
    time_set = 1'b0; activatealarm = 1'b0;
    alarm_set = 1'b1; run_clock = 1'b1; sethrs1min0 = 1'b0; runset = 1'b0;
    sb.push_back('{"aset_with_run", mk(0, 0, 2, 0, 4, 1'b0)});
    step(4);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.exp); end
    idle_inputs();
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    time_set = 1'b1; runset = 1'b0; sethrs1min0 = 1'b1;
    step(23);
    sethrs1min0 = 1'b0;
    sb.push_back('{"set_23_59", mk(23, 59, 0, 0, 0, 1'b0)});
    step(59);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.exp); end
    sb.push_back('{"min_wrap_no_carry", mk(23, 0, 0, 0, 0, 1'b0)});
    step(1);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.exp); end
    step(59);
    time_set = 1'b0; runset = 1'b1; run_clock = 1'b1;
    sb.push_back('{"run_23_59_59", mk(23, 59, 59, 0, 0, 1'b0)});
    step(118);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.exp); end
    sb.push_back('{"day_wrap", mk(0, 0, 0, 0, 0, 1'b0)});
    step(2);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.exp); end
    sb.push_back('{"pre_async", mk(0, 0, 1, 0, 0, 1'b0)});
    step(3);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.exp); end
    // Mid-second (phase=1): reset between edges must clear immediately.
    #2;
    reset = 1'b1;
    sb.push_back('{"async_reset", mk(0, 0, 0, 0, 0, 1'b0)});
    #1;
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.exp); end
    #1;
    reset = 1'b0;
    // With phase cleared, one edge must not yet advance sec; the second must.
    sb.push_back('{"phase_cleared", mk(0, 0, 0, 0, 0, 1'b0)});
    step(1);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.exp); end
    sb.push_back('{"first_second", mk(0, 0, 1, 0, 0, 1'b0)});
    step(1);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.exp); end
    idle_inputs();
  endtask

  // Global time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_time_set();
    test_alarm_set();
    test_run_alarm();
    test_alarm_clear();
    test_back_to_back();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
